// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates core and debug access to the data memory; the debug port can lock out the core.
// Optional round-robin arbitration under contention is enabled by DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_CoreReq,
  input  logic                  i_CoreWriteEnable,
  input  logic [ADDR_WIDTH-1:0] i_CoreAddress,
  input  logic [31:0]           i_CoreDataIn,
  output logic                  o_CoreGrant,
  output logic                  o_CoreDataValid,
  output logic [31:0]           o_CoreDataOut,
  output logic                  o_CoreError,
  input  logic                  i_DbgReq,
  input  logic                  i_DbgWriteEnable,
  input  logic [ADDR_WIDTH-1:0] i_DbgAddress,
  input  logic [31:0]           i_DbgDataIn,
  input  logic                  i_DbgLock,
  output logic                  o_DbgGrant,
  output logic                  o_DbgDataValid,
  output logic [31:0]           o_DbgDataOut,
  output logic                  o_DbgError,
  output logic                  o_MemWriteEnable,
  output logic [ADDR_WIDTH-1:0] o_MemAddress,
  output logic [31:0]           o_MemDataIn,
  input  logic [31:0]           i_MemDataOut,
  input  logic                  i_MemAddressMisaligned
);
  typedef enum logic {OPEN, DBG_LOCKED} state_t;
  state_t state, nextState;
  logic lockedNow, dbgFirst;
  logic respCore, respDbg, respErr;
  logic [31:0] coreHold, dbgHold;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic contested;
  assign contested = !i_Reset && !lockedNow && i_CoreReq && i_DbgReq;
  // after a contested grant the loser gets priority next time
  always_ff @(posedge i_Clock)
    if (i_Reset) dbgFirst <= 1'b0;
    else if (contested) dbgFirst <= o_CoreGrant;
`else
  assign dbgFirst = 1'b0;
`endif
  always_comb begin
    lockedNow = state == DBG_LOCKED && i_DbgLock;
    o_DbgGrant = !i_Reset && i_DbgReq && (lockedNow || !i_CoreReq || dbgFirst);
    o_CoreGrant = !i_Reset && !lockedNow && i_CoreReq && !(i_DbgReq && dbgFirst);
    nextState = (lockedNow || (o_DbgGrant && i_DbgLock)) ? DBG_LOCKED : OPEN;
    o_MemAddress = o_DbgGrant ? i_DbgAddress : i_CoreAddress;
    o_MemDataIn = o_DbgGrant ? i_DbgDataIn : i_CoreDataIn;
    o_MemWriteEnable = !i_MemAddressMisaligned &&
                       (o_CoreGrant ? i_CoreWriteEnable : o_DbgGrant && i_DbgWriteEnable);
  end
  always_ff @(posedge i_Clock)
    if (i_Reset) state <= OPEN;
    else state <= nextState;
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      respCore <= 1'b0;
      respDbg <= 1'b0;
      respErr <= 1'b0;
      coreHold <= '0;
      dbgHold <= '0;
    end else begin
      respCore <= o_CoreGrant;
      respDbg <= o_DbgGrant;
      respErr <= i_MemAddressMisaligned;
      if (respCore) coreHold <= i_MemDataOut;
      if (respDbg) dbgHold <= i_MemDataOut;
    end
  // a response pending across a reset cycle is dropped
  assign o_CoreDataValid = respCore && !i_Reset;
  assign o_DbgDataValid = respDbg && !i_Reset;
  assign o_CoreError = o_CoreDataValid && respErr;
  assign o_DbgError = o_DbgDataValid && respErr;
  assign o_CoreDataOut = i_Reset ? '0 : respCore ? i_MemDataOut : coreHold;
  assign o_DbgDataOut = i_Reset ? '0 : respDbg ? i_MemDataOut : dbgHold;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, directed corner sequences and randomized run against a reference model.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic i_Clock = 0, i_Reset;
  logic i_CoreReq, i_CoreWriteEnable, i_DbgReq, i_DbgWriteEnable, i_DbgLock, i_MemAddressMisaligned;
  logic [31:0] i_CoreAddress, i_CoreDataIn, i_DbgAddress, i_DbgDataIn, i_MemDataOut;
  logic o_CoreGrant, o_CoreDataValid, o_CoreError, o_DbgGrant, o_DbgDataValid, o_DbgError, o_MemWriteEnable;
  logic [31:0] o_CoreDataOut, o_DbgDataOut, o_MemAddress, o_MemDataIn;
  int nChecks = 0, nFail = 0;

  dmem_arbiter #(.ADDR_WIDTH(32)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .i_CoreReq(i_CoreReq), .i_CoreWriteEnable(i_CoreWriteEnable), .i_CoreAddress(i_CoreAddress),
    .i_CoreDataIn(i_CoreDataIn), .o_CoreGrant(o_CoreGrant), .o_CoreDataValid(o_CoreDataValid),
    .o_CoreDataOut(o_CoreDataOut), .o_CoreError(o_CoreError),
    .i_DbgReq(i_DbgReq), .i_DbgWriteEnable(i_DbgWriteEnable), .i_DbgAddress(i_DbgAddress),
    .i_DbgDataIn(i_DbgDataIn), .i_DbgLock(i_DbgLock), .o_DbgGrant(o_DbgGrant),
    .o_DbgDataValid(o_DbgDataValid), .o_DbgDataOut(o_DbgDataOut), .o_DbgError(o_DbgError),
    .o_MemWriteEnable(o_MemWriteEnable), .o_MemAddress(o_MemAddress), .o_MemDataIn(o_MemDataIn),
    .i_MemDataOut(i_MemDataOut), .i_MemAddressMisaligned(i_MemAddressMisaligned)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic idle();
    i_CoreReq = 0; i_CoreWriteEnable = 0; i_CoreAddress = 0; i_CoreDataIn = 0;
    i_DbgReq = 0; i_DbgWriteEnable = 0; i_DbgAddress = 0; i_DbgDataIn = 0; i_DbgLock = 0;
    i_MemAddressMisaligned = 0; i_MemDataOut = 0;
  endtask

  task automatic doReset();
    idle();
    i_Reset = 1;
    tick();
    tick();
    i_Reset = 0;
  endtask

  typedef struct {
    logic creq, cwe; logic [31:0] caddr, cdata;
    logic dreq, dwe; logic [31:0] daddr, ddata;
    logic mis;
    logic eCG, eDG, eWE; logic [31:0] eAddr, eDin;
  } vec_t;
  vec_t vecs[6];

  // reference model state
  bit mLocked, mDbgFirst, mPendC, mPendD, mPendErr;
  logic [31:0] mHoldC, mHoldD;

  initial begin
    vecs[0] = '{1,0,32'h10,32'h0, 0,0,32'h0,32'h0, 0, 1,0,0,32'h10,32'h0};
    vecs[1] = '{0,0,32'h44,32'h1, 1,1,32'h20,32'hCAFE0001, 0, 0,1,1,32'h20,32'hCAFE0001};
    vecs[2] = '{1,1,32'h31,32'h77, 0,0,32'h0,32'h0, 1, 1,0,0,32'h31,32'h77};
    vecs[3] = '{0,1,32'h58,32'h99, 0,1,32'h60,32'h5, 0, 0,0,0,32'h58,32'h99};
    vecs[4] = '{1,1,32'h100,32'hA, 1,0,32'h200,32'hB, 0, 1,0,1,32'h100,32'hA};
    vecs[5] = '{1,1,32'h104,32'hC, 1,0,32'h204,32'hD, 0, !RR,RR,!RR,RR ? 32'h204 : 32'h104,RR ? 32'hD : 32'hC};

    idle();
    i_Reset = 1;
    tick();
    i_CoreReq = 1; i_DbgReq = 1; i_CoreWriteEnable = 1; i_DbgWriteEnable = 1;
    #4;
    chk("reset_core_grant", o_CoreGrant, 0);
    chk("reset_dbg_grant", o_DbgGrant, 0);
    chk("reset_mem_we", o_MemWriteEnable, 0);
    chk("reset_core_valid", o_CoreDataValid, 0);
    chk("reset_dbg_valid", o_DbgDataValid, 0);
    chk("reset_core_dout", o_CoreDataOut, 0);
    chk("reset_dbg_dout", o_DbgDataOut, 0);
    doReset();

    foreach (vecs[i]) begin
      i_CoreReq = vecs[i].creq; i_CoreWriteEnable = vecs[i].cwe;
      i_CoreAddress = vecs[i].caddr; i_CoreDataIn = vecs[i].cdata;
      i_DbgReq = vecs[i].dreq; i_DbgWriteEnable = vecs[i].dwe;
      i_DbgAddress = vecs[i].daddr; i_DbgDataIn = vecs[i].ddata;
      i_MemAddressMisaligned = vecs[i].mis;
      #4;
      chk($sformatf("vec%0d_core_grant", i), o_CoreGrant, vecs[i].eCG);
      chk($sformatf("vec%0d_dbg_grant", i), o_DbgGrant, vecs[i].eDG);
      chk($sformatf("vec%0d_mem_we", i), o_MemWriteEnable, vecs[i].eWE);
      chk($sformatf("vec%0d_mem_addr", i), o_MemAddress, vecs[i].eAddr);
      chk($sformatf("vec%0d_mem_din", i), o_MemDataIn, vecs[i].eDin);
      tick();
    end

    // aligned core read
    doReset();
    i_CoreReq = 1; i_CoreAddress = 32'h10;
    #4;
    chk("rd_grant", o_CoreGrant, 1);
    chk("rd_addr", o_MemAddress, 32'h10);
    tick();
    idle(); i_MemDataOut = 32'hDEADBEEF;
    #4;
    chk("rd_valid", o_CoreDataValid, 1);
    chk("rd_data", o_CoreDataOut, 32'hDEADBEEF);
    chk("rd_err", o_CoreError, 0);
    chk("rd_dbg_valid", o_DbgDataValid, 0);
    tick();
    i_MemDataOut = 32'h11112222;
    #4;
    chk("rd_valid_once", o_CoreDataValid, 0);
    chk("rd_data_hold", o_CoreDataOut, 32'hDEADBEEF);

    // misaligned debug write
    doReset();
    i_DbgReq = 1; i_DbgWriteEnable = 1; i_DbgAddress = 32'h3; i_DbgDataIn = 32'h12345678;
    i_MemAddressMisaligned = 1;
    #4;
    chk("mis_dbg_grant", o_DbgGrant, 1);
    chk("mis_mem_we", o_MemWriteEnable, 0);
    chk("mis_mem_din", o_MemDataIn, 32'h12345678);
    tick();
    idle(); i_MemDataOut = 32'h0BADF00D;
    #4;
    chk("mis_dbg_valid", o_DbgDataValid, 1);
    chk("mis_dbg_err", o_DbgError, 1);
    chk("mis_dbg_data", o_DbgDataOut, 32'h0BADF00D);
    chk("mis_core_err", o_CoreError, 0);
    tick();
    #4;
    chk("mis_err_clear", o_DbgError, 0);

    // sustained contention
    doReset();
    i_CoreReq = 1; i_DbgReq = 1;
    for (int k = 0; k < 4; k++) begin
      #4;
      chk($sformatf("contend%0d_core", k), o_CoreGrant, RR ? (k % 2 == 0) : 1);
      chk($sformatf("contend%0d_dbg", k), o_DbgGrant, RR ? (k % 2 == 1) : 0);
      tick();
    end

    // debug lock excludes core until released
    doReset();
    i_DbgReq = 1; i_DbgLock = 1;
    #4;
    chk("lock_take", o_DbgGrant, 1);
    tick();
    for (int k = 1; k <= 3; k++) begin
      i_CoreReq = 1; i_DbgReq = (k == 2);
      #4;
      chk($sformatf("lock%0d_core", k), o_CoreGrant, 0);
      chk($sformatf("lock%0d_dbg", k), o_DbgGrant, k == 2);
      tick();
    end
    i_DbgLock = 0; i_DbgReq = 0;
    #4;
    chk("lock_exit_core", o_CoreGrant, 1);
    tick();

    // reset right after a grant drops the response
    doReset();
    i_CoreReq = 1; i_CoreAddress = 32'h40;
    #4;
    chk("rstgr_grant", o_CoreGrant, 1);
    tick();
    i_Reset = 1; i_MemDataOut = 32'hFFFF0000;
    #4;
    chk("rstgr_valid_n", o_CoreDataValid, 0);
    chk("rstgr_dout_n", o_CoreDataOut, 0);
    chk("rstgr_grant_n", o_CoreGrant, 0);
    chk("rstgr_we_n", o_MemWriteEnable, 0);
    tick();
    i_Reset = 0; i_CoreReq = 0;
    #4;
    chk("rstgr_valid_n1", o_CoreDataValid, 0);
    chk("rstgr_dout_n1", o_CoreDataOut, 0);
    tick();

    // randomized run against the reference model
    doReset();
    {mLocked, mDbgFirst, mPendC, mPendD, mPendErr} = '0;
    mHoldC = 0; mHoldD = 0;
    for (int n = 0; n < 600; n++) begin
      bit eCG, eDG, eWE;
      logic [31:0] eAddr, eDin;
      i_Reset = ($urandom_range(0, 39) == 0);
      i_CoreReq = $urandom_range(0, 2) != 0; i_CoreWriteEnable = $urandom_range(0, 1);
      i_CoreAddress = $urandom; i_CoreDataIn = $urandom;
      i_DbgReq = $urandom_range(0, 1); i_DbgWriteEnable = $urandom_range(0, 1);
      i_DbgAddress = $urandom; i_DbgDataIn = $urandom;
      if ($urandom_range(0, 5) == 0) i_DbgLock = ~i_DbgLock;
      i_MemAddressMisaligned = $urandom_range(0, 3) == 0;
      i_MemDataOut = $urandom;
      if (i_Reset) {eCG, eDG} = 2'b00;
      else if (mLocked && i_DbgLock) begin eCG = 0; eDG = i_DbgReq; end
      else if (i_CoreReq && i_DbgReq) begin eDG = RR && mDbgFirst; eCG = !eDG; end
      else begin eCG = i_CoreReq; eDG = i_DbgReq; end
      eWE = (eCG ? i_CoreWriteEnable : eDG && i_DbgWriteEnable) && !i_MemAddressMisaligned;
      eAddr = eDG ? i_DbgAddress : i_CoreAddress;
      eDin = eDG ? i_DbgDataIn : i_CoreDataIn;
      #4;
      chk("rnd_core_grant", o_CoreGrant, eCG);
      chk("rnd_dbg_grant", o_DbgGrant, eDG);
      chk("rnd_mem_we", o_MemWriteEnable, eWE);
      chk("rnd_mem_addr", o_MemAddress, eAddr);
      chk("rnd_mem_din", o_MemDataIn, eDin);
      chk("rnd_core_valid", o_CoreDataValid, !i_Reset && mPendC);
      chk("rnd_dbg_valid", o_DbgDataValid, !i_Reset && mPendD);
      chk("rnd_core_err", o_CoreError, !i_Reset && mPendC && mPendErr);
      chk("rnd_dbg_err", o_DbgError, !i_Reset && mPendD && mPendErr);
      chk("rnd_core_dout", o_CoreDataOut, i_Reset ? 0 : mPendC ? i_MemDataOut : mHoldC);
      chk("rnd_dbg_dout", o_DbgDataOut, i_Reset ? 0 : mPendD ? i_MemDataOut : mHoldD);
      if (i_Reset) begin
        {mLocked, mDbgFirst, mPendC, mPendD, mPendErr} = '0;
        mHoldC = 0; mHoldD = 0;
      end else begin
        if (mPendC) mHoldC = i_MemDataOut;
        if (mPendD) mHoldD = i_MemDataOut;
        if (!(mLocked && i_DbgLock) && i_CoreReq && i_DbgReq) mDbgFirst = eCG;
        mLocked = i_DbgLock && (mLocked || eDG);
        mPendC = eCG; mPendD = eDG; mPendErr = i_MemAddressMisaligned;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, width of all address ports.
REQ-002 Ports, clock and reset first:
- i_Clock  in  1  clock; all state changes on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_CoreReq  in  1  core access request.
- i_CoreWriteEnable  in  1  core write (1) or read (0).
- i_CoreAddress  in  ADDR_WIDTH  core byte address.
- i_CoreDataIn  in  32  core write data.
- o_CoreGrant  out  1  core request accepted this cycle.
- o_CoreDataValid  out  1  core response valid.
- o_CoreDataOut  out  32  core response data.
- o_CoreError  out  1  core response is misaligned-access error.
- i_DbgReq, i_DbgWriteEnable, i_DbgAddress, i_DbgDataIn  in  1/1/ADDR_WIDTH/32  debug/loader port, same meaning as core.
- i_DbgLock  in  1  debug holds exclusive ownership while high.
- o_DbgGrant, o_DbgDataValid, o_DbgDataOut, o_DbgError  out  1/1/32/1  debug port, same meaning as core.
- o_MemWriteEnable  out  1  data memory write strobe.
- o_MemAddress  out  ADDR_WIDTH  data memory address.
- o_MemDataIn  out  32  data memory write data.
- i_MemDataOut  in  32  data memory registered output (1-cycle latency).
- i_MemAddressMisaligned  in  1  memory flags current address misaligned.

Function
REQ-003 At most one of o_CoreGrant/o_DbgGrant SHALL be high per cycle; grants are combinational from requests and registered state.
REQ-004 Granted cycle N: o_MemAddress/o_MemDataIn SHALL carry the winner's address/data; o_MemWriteEnable = winner's write enable AND NOT i_MemAddressMisaligned.
REQ-005 No grant: o_MemWriteEnable SHALL be 0; o_MemAddress/o_MemDataIn SHALL carry core inputs.
REQ-006 Cycle N+1: winner's DataValid SHALL be 1 for exactly one cycle, DataOut = i_MemDataOut (reads and writes alike), Error = registered misaligned flag from cycle N; other port's DataValid/Error 0.
REQ-007 Non-valid cycles: DataOut SHALL hold last value; Error SHALL be 0.
REQ-008 FSM states OPEN and DBG_LOCKED; OPEN -> DBG_LOCKED when debug granted with i_DbgLock=1; DBG_LOCKED -> OPEN on first cycle i_DbgLock=0.
REQ-009 DBG_LOCKED: core SHALL never be granted; debug granted whenever i_DbgReq=1.
REQ-010 Exit cycle (DBG_LOCKED, i_DbgLock=0): arbitration SHALL be as in OPEN that same cycle.
REQ-011 OPEN, single requester: that requester SHALL be granted.
REQ-012 OPEN, both requesting: winner per REQ-016.
REQ-013 Misaligned write SHALL not modify memory; arbitration and pointer update proceed normally.

Reset
REQ-014 Under i_Reset: state OPEN, priority pointer = core, response tracking cleared, all DataValid/Error/DataOut 0, grants and o_MemWriteEnable 0.
REQ-015 Reset asserted in cycle N after a cycle N-1 grant: response SHALL be discarded; no DataValid in cycle N or N+1.

Configuration
REQ-016 Macro DMEM_ARB_ROUND_ROBIN_EN: defined -> 1-bit pointer flips to the non-winner after each contested grant, winner = pointer side; undefined -> core always wins contention in OPEN, no pointer state.

Verification
REQ-017 Core read 0x00000010 alone, memory returns 0xDEADBEEF -> o_CoreGrant cycle N, o_CoreDataValid=1 and o_CoreDataOut=0xDEADBEEF cycle N+1, o_CoreError=0.
REQ-018 Debug write 0x00000003 data 0x12345678, memory flags misaligned -> o_MemWriteEnable=0, o_DbgDataValid=1 and o_DbgError=1 cycle N+1.
REQ-019 Both request 4 consecutive cycles, macro defined -> grants core,dbg,core,dbg; undefined -> core x4.
REQ-020 Debug granted with i_DbgLock=1, core requests 3 cycles, lock drops cycle 4 -> core grants 0 in cycles 1-3, core granted cycle 4 if it wins per REQ-016.
REQ-021 Core read granted, i_Reset next cycle -> no o_CoreDataValid in either following cycle; all outputs 0.
